// File: rtl/uart_chk_pkg.sv
// Shared definitions for the UART receive-frame checker: frame-position state
// encoding, parity type codes and the expected-parity helper.
package uart_chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // acc is the XOR of all data bits; even parity repeats it, odd parity inverts it.
  function automatic logic exp_par_bit(input logic acc, input logic typ);
    return (typ == PAR_EVEN) ? acc : ~acc;
  endfunction

endpackage

// File: rtl/uart_err_stat.sv
// Sticky error status and saturating errored-frame counter for the register block.
// A clear arriving with an error event is applied first, so the event survives.
module uart_err_stat
  import uart_chk_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strt_ev,
  input  logic                     par_ev,
  input  logic                     stp_ev,
  input  logic                     err_clr,
  output logic                     sticky_strt,
  output logic                     sticky_par,
  output logic                     sticky_stp,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  logic                     sticky_strt_q, sticky_strt_d;
  logic                     sticky_par_q,  sticky_par_d;
  logic                     sticky_stp_q,  sticky_stp_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q,     err_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_base;
  logic                     any_ev;

  always_comb begin
    any_ev       = strt_ev | par_ev | stp_ev;
    sticky_strt_d = (err_clr ? 1'b0 : sticky_strt_q) | strt_ev;
    sticky_par_d  = (err_clr ? 1'b0 : sticky_par_q)  | par_ev;
    sticky_stp_d  = (err_clr ? 1'b0 : sticky_stp_q)  | stp_ev;
    cnt_base      = err_clr ? '0 : err_cnt_q;
    err_cnt_d     = cnt_base;
    if (any_ev && (cnt_base != '1)) begin
      err_cnt_d = cnt_base + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_strt_q <= 1'b0;
      sticky_par_q  <= 1'b0;
      sticky_stp_q  <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      sticky_strt_q <= sticky_strt_d;
      sticky_par_q  <= sticky_par_d;
      sticky_stp_q  <= sticky_stp_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign sticky_strt = sticky_strt_q;
  assign sticky_par  = sticky_par_q;
  assign sticky_stp  = sticky_stp_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: rtl/uart_frame_chk.sv
// UART receive-frame checker: walks start/data/parity/stop positions one sampler
// strobe at a time, assembles the data word and flags framing and parity errors.
module uart_frame_chk
  import uart_chk_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_valid,
  input  logic                     sampled_bit,
  input  logic                     frm_bgn,
  input  logic                     par_en,
  input  logic                     par_typ,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     strt_err,
  output logic                     par_err,
  output logic                     stp_err,
  output logic                     sticky_strt,
  output logic                     sticky_par,
  output logic                     sticky_stp,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  logic [1:0]            state_q,      state_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic                  par_acc_q,    par_acc_d;
  logic                  par_en_q,     par_en_d;
  logic                  par_typ_q,    par_typ_d;
  logic                  frm_par_q,    frm_par_d;
  logic                  frm_stp_q,    frm_stp_d;
  logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  strt_err_q,   strt_err_d;
  logic                  par_err_q,    par_err_d;
  logic                  stp_err_q,    stp_err_d;
  logic                  strt_ev, par_ev, stp_ev;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    par_acc_d    = par_acc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    frm_par_d    = frm_par_q;
    frm_stp_d    = frm_stp_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    strt_err_d   = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    strt_ev      = 1'b0;
    par_ev       = 1'b0;
    stp_ev       = 1'b0;

    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (frm_bgn) begin
            if (!sampled_bit) begin
              par_en_d  = par_en;
              par_typ_d = par_typ;
              idx_d     = '0;
              par_acc_d = 1'b0;
              frm_par_d = 1'b0;
              frm_stp_d = 1'b0;
              state_d   = ST_DATA;
            end else begin
              strt_err_d = 1'b1;
              strt_ev    = 1'b1;
            end
          end
        end
        ST_DATA: begin
          // Shift in at the MSB so the first bit on the line ends up at bit 0.
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ sampled_bit;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = par_en_q ? ST_PAR : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_PAR: begin
          frm_par_d = (sampled_bit != exp_par_bit(par_acc_q, par_typ_q));
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          frm_stp_d = frm_stp_q | ~sampled_bit;
          if (idx_q == LAST_STOP) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            par_err_d    = frm_par_q;
            stp_err_d    = frm_stp_d;
            par_ev       = frm_par_q;
            stp_ev       = frm_stp_d;
            idx_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      par_acc_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      frm_par_q    <= 1'b0;
      frm_stp_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      strt_err_q   <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      par_acc_q    <= par_acc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      frm_par_q    <= frm_par_d;
      frm_stp_q    <= frm_stp_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      strt_err_q   <= strt_err_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  // Status sees the same combinational events as the pulse flops, so both update together.
  uart_err_stat #(
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_err_stat (
    .clk        (clk),
    .rst        (rst),
    .strt_ev    (strt_ev),
    .par_ev     (par_ev),
    .stp_ev     (stp_ev),
    .err_clr    (err_clr),
    .sticky_strt(sticky_strt),
    .sticky_par (sticky_par),
    .sticky_stp (sticky_stp),
    .err_cnt    (err_cnt)
  );

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign strt_err   = strt_err_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_frame_chk.sv
// Bench for uart_frame_chk: two instances (1 stop bit / 8-bit counter and
// 2 stop bits / 2-bit counter) checked against a frame-level reference model.
module tb_uart_frame_chk;
  import uart_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bv [2];
  logic       sb [2];
  logic       fb [2];
  logic       pen [2];
  logic       ptyp [2];
  logic       clr [2];
  logic [7:0] dout [2];
  logic       dv [2];
  logic       se [2];
  logic       pe [2];
  logic       te [2];
  logic       ss [2];
  logic       sp [2];
  logic       st [2];
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the status block, one entry per instance.
  int m_cnt [2];
  int m_max [2];
  bit m_ss [2];
  bit m_sp [2];
  bit m_st [2];

  always #5 clk = ~clk;

  uart_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .bit_valid(bv[0]), .sampled_bit(sb[0]), .frm_bgn(fb[0]),
    .par_en(pen[0]), .par_typ(ptyp[0]), .err_clr(clr[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .strt_err(se[0]), .par_err(pe[0]), .stp_err(te[0]),
    .sticky_strt(ss[0]), .sticky_par(sp[0]), .sticky_stp(st[0]), .err_cnt(cnt_a)
  );

  uart_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .bit_valid(bv[1]), .sampled_bit(sb[1]), .frm_bgn(fb[1]),
    .par_en(pen[1]), .par_typ(ptyp[1]), .err_clr(clr[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .strt_err(se[1]), .par_err(pe[1]), .stp_err(te[1]),
    .sticky_strt(ss[1]), .sticky_par(sp[1]), .sticky_stp(st[1]), .err_cnt(cnt_b)
  );

  function automatic logic [7:0] get_cnt(input int u);
    return (u == 0) ? cnt_a : {6'b0, cnt_b};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_ss[u] = 0; m_sp[u] = 0; m_st[u] = 0;
    end
  endtask

  task automatic model_event(input int u, input bit c, input bit s, input bit p, input bit t);
    if (c) begin
      m_ss[u] = 0; m_sp[u] = 0; m_st[u] = 0; m_cnt[u] = 0;
    end
    m_ss[u] = m_ss[u] | s;
    m_sp[u] = m_sp[u] | p;
    m_st[u] = m_st[u] | t;
    if ((s | p | t) && (m_cnt[u] < m_max[u])) m_cnt[u]++;
  endtask

  // Called at a falling edge; holds the strobe through one rising edge and returns
  // at the next falling edge, where the registered response is visible.
  task automatic strobe(input int u, input logic b, input logic bgn);
    bv[u] = 1'b1; sb[u] = b; fb[u] = bgn;
    @(negedge clk);
    bv[u] = 1'b0; fb[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int u, input logic [7:0] data, input bit pen_v,
                            input bit ptyp_v, input bit par_bit, input bit [1:0] stops,
                            input bit clr_last, input bit noise, input string tag);
    bit exp_pe;
    bit exp_te;
    int nstop;
    nstop = (u == 0) ? 1 : 2;
    pen[u] = pen_v; ptyp[u] = ptyp_v;
    strobe(u, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        pen[u] = 1'($urandom); ptyp[u] = 1'($urandom);
      end
      strobe(u, data[i], noise ? 1'($urandom) : 1'b0);
    end
    if (pen_v) strobe(u, par_bit, 1'b0);
    for (int s = 0; s < nstop; s++) begin
      if (s == nstop - 1) clr[u] = clr_last;
      strobe(u, stops[s], 1'b0);
      clr[u] = 1'b0;
    end
    exp_pe = pen_v && (par_bit != ((^data) ^ ptyp_v));
    exp_te = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
    model_event(u, clr_last, 1'b0, exp_pe, exp_te);
    n_checks++;
    if (dv[u] !== 1'b1 || dout[u] !== data || pe[u] !== exp_pe || te[u] !== exp_te) begin
      n_errors++;
      $display("FAIL %s frame dut%0d: dv=%b data=%h par_err=%b stp_err=%b, expected dv=1 data=%h par_err=%b stp_err=%b",
               tag, u, dv[u], dout[u], pe[u], te[u], data, exp_pe, exp_te);
    end
    n_checks++;
    if ({ss[u], sp[u], st[u]} !== {m_ss[u], m_sp[u], m_st[u]} || get_cnt(u) !== 8'(m_cnt[u])) begin
      n_errors++;
      $display("FAIL %s status dut%0d: sticky=%b%b%b cnt=%0d, expected sticky=%b%b%b cnt=%0d",
               tag, u, ss[u], sp[u], st[u], get_cnt(u), m_ss[u], m_sp[u], m_st[u], m_cnt[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      bv[u] = 0; sb[u] = 0; fb[u] = 0; pen[u] = 0; ptyp[u] = 0; clr[u] = 0;
    end
    model_reset();
    idle(3);
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (dout[u] !== 8'h00 || dv[u] !== 1'b0 || se[u] !== 1'b0 || pe[u] !== 1'b0 ||
          te[u] !== 1'b0 || ss[u] !== 1'b0 || sp[u] !== 1'b0 || st[u] !== 1'b0 ||
          get_cnt(u) !== 8'h00) begin
        n_errors++;
        $display("FAIL reset dut%0d: data=%h dv=%b se=%b pe=%b te=%b sticky=%b%b%b cnt=%0d, expected all 0",
                 u, dout[u], dv[u], se[u], pe[u], te[u], ss[u], sp[u], st[u], get_cnt(u));
      end
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_even_parity();
    send_frame(0, 8'h55, 1'b1, PAR_EVEN, 1'b0, 2'b11, 1'b0, 1'b0, "even_parity");
    idle(1);
    n_checks++;
    if (dv[0] !== 1'b0 || pe[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL even_pulse: dv=%b par_err=%b, expected dv=0 par_err=0", dv[0], pe[0]);
    end
  endtask

  task automatic test_odd_parity();
    send_frame(0, 8'h55, 1'b1, PAR_ODD, 1'b0, 2'b11, 1'b0, 1'b0, "odd_parity");
    idle(2);
    n_checks++;
    if (dv[0] !== 1'b0 || pe[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL odd_hold: dv=%b par_err=%b, expected dv=0 par_err=1", dv[0], pe[0]);
    end
  endtask

  task automatic test_start_err();
    strobe(0, 1'b1, 1'b1);
    model_event(0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (se[0] !== 1'b1 || dv[0] !== 1'b0 || ss[0] !== 1'b1 || get_cnt(0) !== 8'(m_cnt[0])) begin
      n_errors++;
      $display("FAIL start_err: se=%b dv=%b sticky_strt=%b cnt=%0d, expected se=1 dv=0 sticky_strt=1 cnt=%0d",
               se[0], dv[0], ss[0], get_cnt(0), m_cnt[0]);
    end
    strobe(0, 1'b0, 1'b0);
    n_checks++;
    if (se[0] !== 1'b0 || dv[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL start_err_pulse: se=%b dv=%b, expected se=0 dv=0", se[0], dv[0]);
    end
    send_frame(0, 8'h3C, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1'b0, 1'b0, "after_start_err");
  endtask

  task automatic test_stop2_clr();
    send_frame(1, 8'h96, 1'b1, PAR_EVEN, 1'b1, 2'b11, 1'b0, 1'b0, "b_par_err");
    idle(1);
    send_frame(1, 8'h0F, 1'b0, PAR_EVEN, 1'b0, 2'b01, 1'b1, 1'b0, "b_stop2_clr");
    idle(1);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      send_frame(1, 8'(k * 37), 1'b0, PAR_EVEN, 1'b0, 2'b10, 1'b0, 1'b0, "b_saturate");
      idle(1);
    end
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    model_event(1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (get_cnt(1) !== 8'h00 || ss[1] !== 1'b0 || sp[1] !== 1'b0 || st[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL b_clear: cnt=%0d sticky=%b%b%b, expected cnt=0 sticky=000",
               get_cnt(1), ss[1], sp[1], st[1]);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8'hC1, 1'b1, PAR_ODD, 1'b0, 2'b11, 1'b0, 1'b0, "b2b_1");
    send_frame(0, 8'h7E, 1'b1, PAR_EVEN, 1'b0, 2'b11, 1'b0, 1'b0, "b2b_2");
    n_checks++;
    if (dout[0] !== 8'h7E) begin
      n_errors++;
      $display("FAIL b2b_data: data=%h, expected 7e", dout[0]);
    end
    send_frame(0, 8'h00, 1'b0, PAR_EVEN, 1'b0, 2'b00, 1'b0, 1'b0, "b2b_3");
    idle(1);
  endtask

  task automatic test_midframe_reset();
    pen[0] = 1'b1;
    strobe(0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) strobe(0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (dout[u] !== 8'h00 || dv[u] !== 1'b0 || se[u] !== 1'b0 || pe[u] !== 1'b0 ||
          te[u] !== 1'b0 || ss[u] !== 1'b0 || sp[u] !== 1'b0 || st[u] !== 1'b0 ||
          get_cnt(u) !== 8'h00) begin
        n_errors++;
        $display("FAIL mid_reset dut%0d: data=%h dv=%b se=%b pe=%b te=%b sticky=%b%b%b cnt=%0d, expected all 0",
                 u, dout[u], dv[u], se[u], pe[u], te[u], ss[u], sp[u], st[u], get_cnt(u));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    send_frame(0, 8'hA3, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1'b0, 1'b0, "after_reset");
    idle(1);
  endtask

  task automatic test_random();
    for (int u = 0; u < 2; u++) begin
      for (int it = 0; it < 60; it++) begin
        int         op;
        logic [7:0] data;
        bit         pv, tv, pbit;
        bit [1:0]   stops;
        int         gap;
        op = $urandom_range(0, 9);
        if (op == 0) begin
          strobe(u, 1'b1, 1'b1);
          model_event(u, 1'b0, 1'b1, 1'b0, 1'b0);
          n_checks++;
          if (se[u] !== 1'b1 || dv[u] !== 1'b0 || ss[u] !== 1'b1 || get_cnt(u) !== 8'(m_cnt[u])) begin
            n_errors++;
            $display("FAIL rand_start dut%0d: se=%b dv=%b sticky_strt=%b cnt=%0d, expected se=1 dv=0 sticky_strt=1 cnt=%0d",
                     u, se[u], dv[u], ss[u], get_cnt(u), m_cnt[u]);
          end
        end else if (op == 1) begin
          clr[u] = 1'b1;
          @(negedge clk);
          clr[u] = 1'b0;
          model_event(u, 1'b1, 1'b0, 1'b0, 1'b0);
          n_checks++;
          if (get_cnt(u) !== 8'h00 || {ss[u], sp[u], st[u]} !== 3'b000) begin
            n_errors++;
            $display("FAIL rand_clr dut%0d: cnt=%0d sticky=%b%b%b, expected cnt=0 sticky=000",
                     u, get_cnt(u), ss[u], sp[u], st[u]);
          end
        end else if (op == 2) begin
          strobe(u, 1'($urandom), 1'b0);
          n_checks++;
          if (dv[u] !== 1'b0 || se[u] !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_noise dut%0d: dv=%b se=%b, expected dv=0 se=0", u, dv[u], se[u]);
          end
        end else begin
          data  = 8'($urandom);
          pv    = 1'($urandom);
          tv    = 1'($urandom);
          pbit  = (^data) ^ tv;
          if ($urandom_range(0, 4) == 0) pbit = ~pbit;
          stops[0] = ($urandom_range(0, 4) != 0);
          stops[1] = ($urandom_range(0, 4) != 0);
          send_frame(u, data, pv, tv, pbit, stops, ($urandom_range(0, 9) == 0), 1'b1, "rand_frame");
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            idle(1);
            n_checks++;
            if (dv[u] !== 1'b0) begin
              n_errors++;
              $display("FAIL rand_pulse dut%0d: dv=%b, expected 0", u, dv[u]);
            end
            idle(gap - 1);
          end
        end
      end
      idle(1);
    end
  endtask

  initial begin
    m_max[0] = 255;
    m_max[1] = 3;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_start_err();
    test_stop2_clr();
    test_saturate();
    test_back_to_back();
    test_midframe_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_chk.md
# uart_frame_chk

Parametrised receive-frame checker for the UART RX path. It consumes sampled bits from the oversampling sampler one strobe at a time and tracks frame position with its own state machine. Per frame it checks the start bit, optional even/odd parity and one or two stop bits. It delivers the assembled data word with per-frame error flags, and keeps sticky error status plus a saturating error-frame counter for the register block.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9)
- STOP_BITS, 1, stop bits checked (1 or 2)
- ERR_CNT_WIDTH, 8, error-frame counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- bit_valid  in  1  one-cycle strobe; sampled_bit is valid
- sampled_bit  in  1  majority-voted line sample
- frm_bgn  in  1  from RX FSM; qualifies the bit_valid that carries the start bit
- par_en  in  1  parity bit present
- par_typ  in  1  0 = even, 1 = odd
- err_clr  in  1  clears sticky flags and counter
- data_out  out  DATA_WIDTH  last received word, LSB first on line
- data_valid  out  1  one-cycle pulse; frame complete
- strt_err  out  1  one-cycle pulse; start bit sampled high
- par_err  out  1  frame flag; valid with data_valid
- stp_err  out  1  frame flag; valid with data_valid
- sticky_strt, sticky_par, sticky_stp  out  1 each  sticky status
- err_cnt  out  ERR_CNT_WIDTH  saturating count of frames with any error

## Operation
States: IDLE, DATA, PAR, STOP.
- IDLE: bit_valid with frm_bgn is the start bit.
  - sampled_bit = 0: latch par_en/par_typ, clear the bit index, go to DATA.
  - sampled_bit = 1: pulse strt_err, count the error, stay in IDLE.
  - bit_valid without frm_bgn is ignored.
- DATA: each bit_valid shifts sampled_bit into the shift register LSB first and XORs it into the running parity. After DATA_WIDTH bits, go to PAR if latched par_en is set, else STOP.
- PAR: expected bit = running parity XOR latched par_typ. A mismatch sets the frame par_err. Go to STOP.
- STOP: STOP_BITS bits are checked. Any stop bit = 0 sets the frame stp_err. After the last stop bit, load data_out, pulse data_valid with par_err/stp_err, and return to IDLE.
- frm_bgn outside IDLE is ignored. The frame is not aborted.
- A frame with an error is still delivered.
- par_en/par_typ changes mid-frame have no effect until the next start bit.
- Sticky flags set on the error event and hold until err_clr.
- err_cnt increments once per errored frame (start-error or any par/stp error). It saturates at all ones.
- err_clr on the same cycle as an error event: clear is applied first, then the event. Result: that sticky flag = 1, err_cnt = 1.

## Timing
- All outputs registered.
- strt_err: one cycle after the offending bit_valid.
- data_valid, par_err, stp_err: one cycle after the final stop-bit bit_valid.
  - data_valid is high for exactly one cycle.
  - par_err and stp_err hold until the next data_valid.
- Sticky flags and err_cnt update in the same cycle as the corresponding pulse.
- Back-to-back frames: a start bit strobe may arrive the cycle after the last stop bit strobe. IDLE accepts it in that cycle.
- Reset (any time, including mid-frame): state = IDLE, and every output = 0 (data_out, data_valid, strt_err, par_err, stp_err, sticky flags, err_cnt). The shift register, bit index and parity accumulator are also cleared.
- Bit index width: $clog2(DATA_WIDTH+1). Parity accumulator: 1 bit.

## Structure
- Shared package/header uart_chk_pkg:
  - state encoding localparams ST_IDLE, ST_DATA, ST_PAR, ST_STOP
  - PAR_EVEN = 0, PAR_ODD = 1
- Sub-module uart_err_stat holds the three sticky flags and the saturating counter. Its inputs are three error event pulses plus err_clr. It is instantiated once.

## Test plan
- DATA_WIDTH=8, par_en=1, even; frame start 0, data 0x55, parity 0, stop 1 -> data_out=0x55, data_valid one cycle, all error flags 0, err_cnt=0.
- Same frame with par_typ=odd -> data_valid with par_err=1, sticky_par=1, err_cnt=1, data_out=0x55.
- frm_bgn with sampled_bit=1 -> strt_err one cycle later, no data_valid, state IDLE. A following valid frame is received correctly.
- STOP_BITS=2, second stop bit 0 -> stp_err=1 with data_valid. err_clr on the same cycle -> sticky_stp=1, err_cnt=1.
- ERR_CNT_WIDTH=2, five errored frames -> err_cnt=3 (saturated). Then err_clr -> err_cnt=0 and all sticky flags 0.
- Assert rst after 4 data bits -> all outputs 0 immediately. After release, full frame 0xA3 with par_en=0 -> data_out=0xA3, no errors.
